// File: rtl/hf_1.sv
`default_nettype none
// ============================================================================
//  Module   : hf_1
//  Purpose  : Traffic-light controller: shared tick prescaler, vehicle FSM,
//             phase-locked pedestrian signal and flashing-amber indicator.
//  Revision : 1.0  initial release
// ============================================================================
module hf_1 #(
    parameter int TICK_DIV   = 1,
    parameter int STD_RED    = 4,
    parameter int STD_RY     = 1,
    parameter int STD_GREEN  = 4,
    parameter int STD_YELLOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] std_out,
    output logic [2:0] man_out,
    output logic [2:0] ind_out
);
    localparam int PC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_A   = (STD_RED > STD_RY) ? STD_RED : STD_RY;
    localparam int MAX_B   = (STD_GREEN > STD_YELLOW) ? STD_GREEN : STD_YELLOW;
    localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [PC_W-1:0]  C_PC_LAST   = PC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] C_RED_LAST  = CNT_W'(STD_RED - 1);
    localparam logic [CNT_W-1:0] C_RY_LAST   = CNT_W'(STD_RY - 1);
    localparam logic [CNT_W-1:0] C_GRN_LAST  = CNT_W'(STD_GREEN - 1);
    localparam logic [CNT_W-1:0] C_YEL_LAST  = CNT_W'(STD_YELLOW - 1);
    localparam logic [CNT_W-1:0] C_WALK_LO   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_WALK_HI   = CNT_W'(STD_RED - 2);

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_RY     = 2'd1,
        S_GREEN  = 2'd2,
        S_YELLOW = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fl_q, fl_d;
    logic             w_tick;
    logic [CNT_W-1:0] w_last;

    assign w_tick = (pc_q == C_PC_LAST);

    always_comb begin
        w_last = C_RED_LAST;
        case (state_q)
            S_RED:    w_last = C_RED_LAST;
            S_RY:     w_last = C_RY_LAST;
            S_GREEN:  w_last = C_GRN_LAST;
            S_YELLOW: w_last = C_YEL_LAST;
            default:  w_last = C_RED_LAST;
        endcase
    end

    always_comb begin
        pc_d    = w_tick ? '0 : pc_q + PC_W'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        if (w_tick) begin
            fl_d = ~fl_q;
            if (cnt_q == w_last) begin
                cnt_d = '0;
                case (state_q)
                    S_RED:    state_d = S_RY;
                    S_RY:     state_d = S_GREEN;
                    S_GREEN:  state_d = S_YELLOW;
                    S_YELLOW: state_d = S_RED;
                    default:  state_d = S_RED;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset wins over a coincident tick and drops any phase in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= '0;
            state_q <= S_RED;
            cnt_q   <= '0;
            fl_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
        end
    end

    always_comb begin
        std_out = 3'b100;
        case (state_q)
            S_RED:    std_out = 3'b100;
            S_RY:     std_out = 3'b110;
            S_GREEN:  std_out = 3'b001;
            S_YELLOW: std_out = 3'b010;
            default:  std_out = 3'b100;
        endcase
    end

    // Walk only inside RED, leaving one clearance tick at each end.
    assign man_out = ((state_q == S_RED) && (cnt_q >= C_WALK_LO) && (cnt_q <= C_WALK_HI))
                     ? 3'b001 : 3'b100;
    assign ind_out = fl_q ? 3'b000 : 3'b010;

endmodule
`default_nettype wire

// File: tb/tb_hf_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hf_1
//  Purpose  : Scoreboard bench for hf_1 at TICK_DIV=1 and TICK_DIV=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hf_1;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] std1, man1, ind1;
    logic [2:0] std3, man3, ind3;

    always #50 clk = ~clk;

    hf_1 u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .std_out (std1),
        .man_out (man1),
        .ind_out (ind1)
    );

    hf_1 #(.TICK_DIV(3)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .std_out (std3),
        .man_out (man3),
        .ind_out (ind3)
    );

    typedef struct {
        logic [2:0] std1, man1, ind1;
        logic [2:0] std3, man3, ind3;
        int         phase;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    // Vehicle lamp codes for p = 0..9 with default durations.
    localparam logic [2:0] STD_TBL [10] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b110,
                                            3'b001, 3'b001, 3'b001, 3'b001, 3'b010};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int phase = 0;

    task automatic check(input string name, input int ph, input int c,
                         input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s phase=%0d cyc=%0d: got %b, expected %b", name, ph, c, act, exp);
        end
    endtask

    task automatic check_safe(input string name, input logic [2:0] s, input logic [2:0] m);
        logic ok;
        ok = !(m[0] && (s[0] || s[1])) &&
             (s == 3'b100 || s == 3'b110 || s == 3'b001 || s == 3'b010);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: unsafe/illegal std=%b man=%b, expected legal and exclusive", name, s, m);
        end
    endtask

    function automatic void model(input int c, input int div,
                                  output logic [2:0] s, output logic [2:0] m, output logic [2:0] i);
        int n, p;
        n = c / div;
        p = n % 10;
        s = STD_TBL[p];
        m = (p == 1 || p == 2) ? 3'b001 : 3'b100;
        i = (n % 2 == 1) ? 3'b000 : 3'b010;
    endfunction

    // One clock edge with the given rst level; expectation queued after the edge.
    task automatic step(input logic r);
        exp_t e;
        rst = r;
        @(posedge clk);
        if (!r) cyc = 0;
        else    cyc++;
        model(cyc, 1, e.std1, e.man1, e.ind1);
        model(cyc, 3, e.std3, e.man3, e.ind3);
        e.phase = phase;
        e.cyc   = cyc;
        sb.push_back(e);
        #10;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("std_div1", e.phase, e.cyc, std1, e.std1);
                check("man_div1", e.phase, e.cyc, man1, e.man1);
                check("ind_div1", e.phase, e.cyc, ind1, e.ind1);
                check("std_div3", e.phase, e.cyc, std3, e.std3);
                check("man_div3", e.phase, e.cyc, man3, e.man3);
                check("ind_div3", e.phase, e.cyc, ind3, e.ind3);
                check_safe("safe_div1", std1, man1);
                check_safe("safe_div3", std3, man3);
            end
        end
    end

    initial begin : driver
        int wait_cnt;
        #10;
        // Reset values, held for two edges.
        phase = 1;
        step(1'b0);
        step(1'b0);
        // Full cycle, wrap to n=10, indicator flashing; divide-by-3 runs alongside.
        phase = 2;
        for (int k = 0; k < 12; k++) step(1'b1);
        // Reset in the middle of GREEN, then restart.
        phase = 3;
        step(1'b0);
        for (int k = 0; k < 6; k++) step(1'b1);
        step(1'b0);
        for (int k = 0; k < 8; k++) step(1'b1);
        // Random-length runs with random reset pulses.
        phase = 4;
        for (int run = 0; run < 100; run++) begin
            int len;
            len = $urandom_range(1, 30);
            for (int k = 0; k < $urandom_range(1, 2); k++) step(1'b0);
            for (int k = 0; k < len; k++) step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1);
        end
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
